// File: rtl/shift_pkg.sv
// Shared types for the pipelined barrel shifter: operation and direction encodings.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LOGIC = 2'b00,
        SH_ARITH = 2'b01,
        SH_ROT   = 2'b10,
        SH_RSVD  = 2'b11
    } shift_op_t;

    typedef enum logic {
        SH_LEFT  = 1'b0,
        SH_RIGHT = 1'b1
    } shift_dir_t;

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Streaming interface of the barrel shifter: request side (valid_in/ready_out) and result side
// (valid_out/ready_in).
interface barrel_shifter_pipe_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int LEVELS = $clog2(WIDTH);

    logic              valid_in;
    logic              ready_out;
    logic [WIDTH-1:0]  d_in;
    logic [LEVELS-1:0] sel_in;
    shift_dir_t        shift_dir;
    shift_op_t         operation;
    logic              valid_out;
    logic              ready_in;
    logic [WIDTH-1:0]  d_out;
    logic              carry_out;

    modport slave (
        input  valid_in, d_in, sel_in, shift_dir, operation, ready_in,
        output ready_out, valid_out, d_out, carry_out
    );

    modport master (
        output valid_in, d_in, sel_in, shift_dir, operation, ready_in,
        input  ready_out, valid_out, d_out, carry_out
    );

endinterface

// File: rtl/shift_stage.sv
// One combinational mux level: optionally shifts/rotates by the fixed amount AMT and updates the
// running carry with the last bit pushed off the exiting edge.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             carry_in,
    input  logic             shift_en,
    input  shift_dir_t       dir,
    input  logic             rotate,
    input  logic             fill,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    always_comb begin
        // NOTE: defaults first keep this block purely combinational for every input combination.
        result = d;
        carry  = carry_in;
        if (shift_en) begin
            if (dir == SH_LEFT) begin
                result = {d[WIDTH-AMT-1:0], rotate ? d[WIDTH-1:WIDTH-AMT] : {AMT{1'b0}}};
                carry  = d[WIDTH-AMT];
            end else begin
                result = {rotate ? d[AMT-1:0] : {AMT{fill}}, d[WIDTH-1:AMT]};
                carry  = d[AMT-1];
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined WIDTH-bit barrel shifter: one registered mux level per shift-amount bit, global
// stall enable, original sign bit carried down the pipe for arithmetic right fill.
module barrel_shifter_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    barrel_shifter_pipe_if.slave bus
);

    localparam int LEVELS = $clog2(WIDTH);

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
        $error("barrel_shifter_pipe: WIDTH must be a power of two and at least 4");
    end

    typedef struct packed {
        logic              valid;
        logic [WIDTH-1:0]  data;
        logic              carry;
        logic              sign;
        shift_dir_t        dir;
        shift_op_t         op;
        logic [LEVELS-1:0] sel;
    } stage_t;

    stage_t           pipe_q   [LEVELS];
    stage_t           src      [LEVELS];
    stage_t           nxt      [LEVELS];
    logic [WIDTH-1:0] sh_data  [LEVELS];
    logic             sh_carry [LEVELS];
    logic             en;

    // The whole pipe advances together; a full output slot blocked downstream freezes everything.
    assign en = ~pipe_q[LEVELS-1].valid | bus.ready_in;

    always_comb begin
        src[0] = '{valid: bus.valid_in,
                   data:  bus.d_in,
                   carry: 1'b0,
                   sign:  bus.d_in[WIDTH-1],
                   dir:   bus.shift_dir,
                   op:    bus.operation,
                   sel:   bus.sel_in};
        for (int k = 1; k < LEVELS; k++) begin
            src[k] = pipe_q[k-1];
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        shift_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << k)
        ) u_stage (
            .d        (src[k].data),
            .carry_in (src[k].carry),
            .shift_en (src[k].sel[k]),
            .dir      (src[k].dir),
            .rotate   (src[k].op == SH_ROT),
            .fill     (src[k].sign && src[k].op == SH_ARITH && src[k].dir == SH_RIGHT),
            .result   (sh_data[k]),
            .carry    (sh_carry[k])
        );
    end

    always_comb begin
        for (int k = 0; k < LEVELS; k++) begin
            nxt[k]       = src[k];
            nxt[k].data  = sh_data[k];
            nxt[k].carry = sh_carry[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LEVELS; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (en) begin
            // NOTE: non-blocking so every stage captures its predecessor's pre-edge value.
            for (int k = 0; k < LEVELS; k++) begin
                pipe_q[k] <= nxt[k];
            end
        end
    end

    assign bus.ready_out = en;
    assign bus.valid_out = pipe_q[LEVELS-1].valid;
    assign bus.d_out     = pipe_q[LEVELS-1].data;
    assign bus.carry_out = pipe_q[LEVELS-1].carry;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe: directed known answers, reset flush, back-pressure,
// and an exhaustive randomized-handshake sweep against a plain-arithmetic reference model.
module tb_barrel_shifter_pipe;
    import shift_pkg::*;

    localparam int WIDTH  = 8;
    localparam int LEVELS = 3;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    barrel_shifter_pipe_if #(.WIDTH(WIDTH)) bus ();

    barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   rdy_mode = 0;
    logic rdy_force = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: rotate uses a doubled word, shifts use native operators.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input int s, input int dir,
                                   input int op);
        exp_t                    r;
        logic [2*WIDTH-1:0]      wide;
        logic signed [WIDTH-1:0] sd;
        r.d = d;
        r.c = 1'b0;
        if (s == 0) return r;
        if (op == 2) begin
            wide = {d, d} >> ((dir == 1) ? s : WIDTH - s);
            r.d  = wide[WIDTH-1:0];
            r.c  = (dir == 1) ? r.d[WIDTH-1] : r.d[0];
        end else if (dir == 0) begin
            r.d = d << s;
            r.c = d[WIDTH-s];
        end else begin
            if (op == 1) begin
                sd  = d;
                r.d = sd >>> s;
            end else begin
                r.d = d >> s;
            end
            r.c = d[s-1];
        end
        return r;
    endfunction

    task automatic send(input logic [WIDTH-1:0] d, input int s, input int dir, input int op,
                        input exp_t exp);
        int budget;
        @(negedge clk);
        bus.valid_in  = 1'b1;
        bus.d_in      = d;
        bus.sel_in    = LEVELS'(s);
        bus.shift_dir = shift_dir_t'(dir);
        bus.operation = shift_op_t'(op);
        #1;
        budget = 0;
        while (!bus.ready_out && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!bus.ready_out) begin
            check("accept_timeout", int'(bus.ready_out), 1);
            bus.valid_in = 1'b0;
        end else begin
            sb.push_back(exp);
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge clk);
        #3;
        check("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        case (rdy_mode)
            0:       bus.ready_in = 1'b1;
            1:       bus.ready_in = ($urandom_range(3) != 0);
            default: bus.ready_in = rdy_force;
        endcase
    end

    // Monitor: pops on every transfer, and checks the output holds while stalled.
    logic hold_v = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("hold_stable", int'({bus.d_out, bus.carry_out}), int'(held));
            if (bus.valid_out && bus.ready_in) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", int'(bus.valid_out), 0);
                end else begin
                    e = sb.pop_front();
                    check("result", int'({bus.d_out, bus.carry_out}), int'(e));
                    n_out++;
                end
                hold_v = 1'b0;
            end else if (bus.valid_out) begin
                hold_v = 1'b1;
                held   = {bus.d_out, bus.carry_out};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, %0d words outstanding", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t;
        bus.valid_in  = 1'b0;
        bus.d_in      = '0;
        bus.sel_in    = '0;
        bus.shift_dir = SH_LEFT;
        bus.operation = SH_LOGIC;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", int'(bus.valid_out), 0);
        check("rst_d_out", int'(bus.d_out), 0);
        check("rst_carry_out", int'(bus.carry_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready_out", int'(bus.ready_out), 1);

        // Directed known answers
        send(8'b1101_0010, 3, 0, 0, {8'b1001_0000, 1'b0});
        send(8'b1001_0000, 2, 1, 1, {8'b1110_0100, 1'b0});
        send(8'b1001_0000, 0, 1, 1, {8'b1001_0000, 1'b0});
        send(8'b1101_0010, 3, 1, 2, {8'b0101_1010, 1'b0});
        send(8'b1000_0001, 1, 0, 2, {8'b0000_0011, 1'b1});
        send(8'b1101_0010, 3, 0, 3, {8'b1001_0000, 1'b0});
        send(8'b1101_0010, 2, 1, 0, {8'b0011_0100, 1'b1});
        send(8'b1101_0010, 7, 1, 1, {8'b1111_1111, 1'b1});
        send(8'b0000_0010, 7, 0, 1, {8'b0000_0000, 1'b1});
        send(8'b1000_0001, 7, 1, 2, {8'b0000_0011, 1'b0});
        send(8'b1101_0010, 2, 1, 3, {8'b0011_0100, 1'b1});
        drain();

        // Reset with three words in flight
        send(8'hFF, 0, 0, 0, {8'hFF, 1'b0});
        send(8'h5A, 1, 0, 0, model(8'h5A, 1, 0, 0));
        send(8'hA5, 2, 1, 1, model(8'hA5, 2, 1, 1));
        #1;
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_out", int'(bus.valid_out), 0);
        check("midrst_d_out", int'(bus.d_out), 0);
        check("midrst_carry_out", int'(bus.carry_out), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        #3;
        check("post_rst_no_stale", int'(bus.valid_out), 0);

        // Back-pressure: ready_in low for 4 cycles after the second result
        rdy_mode  = 2;
        rdy_force = 1'b1;
        base      = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [WIDTH-1:0] d;
                    int s, dir, op;
                    d   = WIDTH'($urandom);
                    s   = $urandom_range(WIDTH - 1);
                    dir = $urandom_range(1);
                    op  = $urandom_range(3);
                    send(d, s, dir, op, model(d, s, dir, op));
                end
                idle(1);
            end
            begin
                t = 0;
                while (n_out < base + 2 && t < 100) begin
                    @(negedge clk);
                    #3;
                    t++;
                end
                if (n_out < base + 2) check("bp_wait_timeout", n_out, base + 2);
                rdy_force = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    #3;
                    check("bp_ready_out_low", int'(bus.ready_out), 0);
                end
                rdy_force = 1'b1;
            end
        join
        drain();
        check("bp_count", n_out - base, 8);

        // Exhaustive sweep with random valid gaps and random downstream ready
        rdy_mode = 1;
        for (int d = 0; d < (1 << WIDTH); d++) begin
            for (int s = 0; s < WIDTH; s++) begin
                for (int dir = 0; dir < 2; dir++) begin
                    for (int op = 0; op < 4; op++) begin
                        if ($urandom_range(3) == 0) idle(1);
                        send(WIDTH'(d), s, dir, op, model(WIDTH'(d), s, dir, op));
                    end
                end
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
